pipelined_unary_reducer: RTL and testbench
==========================================

Name: pipelined_unary_reducer

Overview:
- Parametrised, pipelined successor to the combinational unary reduction gate.
- Reduces an N-bit operand to one bit with a per-transaction selectable operator: AND, OR, XOR, NAND, NOR or XNOR.
- Uses a registered radix-K tree, so wide operands close timing.
- Sits in BasicCombinationalLogic/Unary as the reusable reduction block for datapaths that need valid/ready flow control and back-pressure.

Parameters:
N, 8, operand width in bits; legal range 2..1024.
K, 4, tree radix (leaf group width per stage); legal range 2..8.
S, derived localparam = ceil(log_K(N)), number of register stages and latency in cycles; minimum 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
a  input  N  operand.
op  input  3  operator select: 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR, 6/7 reserved.
in_valid  input  1  a/op are valid this cycle.
in_ready  output  1  block accepts a/op this cycle.
c  output  1  reduction result.
op_out  output  3  op that produced c.
out_valid  output  1  c/op_out are valid.
out_ready  input  1  downstream accepts c this cycle.
op_err  output  1  sticky flag, set when a reserved op is accepted.

Behaviour:
- Interface (already decided): single clock clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous): every stage valid bit = 0, out_valid = 0, c = 0, op_out = 0, op_err = 0. Pipeline data registers need no reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage structure:
  - Stage s (1..S) holds a vector of ceil(N/K^s) partial bits, the op code, and valid v[s].
  - Stage S is the output stage: c = its single bit, after final inversion; out_valid = v[S].
- Per-stage ready:
  - r[S] = out_ready || !v[S].
  - r[s] = r[s+1] || !v[s] for s < S.
  - in_ready = r[1]. It is combinational, with no path from in_valid.
- Stage advance: stage s loads from stage s-1 (or from the inputs when s = 1) whenever r[s] is high. v[s] <= v[s-1] (or the input handshake when s = 1).
- Bubbles: bubbles collapse. A stalled output does not block earlier empty stages.
- Latency and throughput:
  - With out_ready held high, c for an operand accepted in cycle t is valid in cycle t+S.
  - Throughput is 1 operand per cycle.
- Reduction rule: base operator is AND for op 0/3, OR for op 1/4, XOR for op 2/5.
- Padding: when a group has fewer than K bits, pad with the identity value (1 for AND, 0 for OR/XOR).
- Inversion: applied once, at the final stage, for op 3/4/5. Intermediate stages always carry the non-inverted partial result.
- op is carried unchanged through the pipeline with its data and appears on op_out.
- Reserved op 6/7: the operand is still accepted. c = 0, op_out = the raw op, op_err is set and stays set until reset.
- Output stability: while out_valid && !out_ready, c and op_out hold stable.
- N = 1 is disallowed by elaboration assertion.
- N <= K: S = 1 and the block is a single registered stage.
- Reset mid-operation: all in-flight results are discarded. No output transfer occurs in the cycle rst_n deasserts.

Decomposition:
- Package unary_pkg holds:
  - typedef enum logic [2:0] unary_op_e (UOP_AND..UOP_XNOR);
  - function identity(unary_op_e);
  - function base_op(unary_op_e);
  - function clog_k(N, K), used to compute S.
- Sub-module unary_reduce_stage (parameters IN_W, K) is instantiated S times via generate. Each stage does the combinational K-way group reduction plus its valid/data/op registers and ready logic.

Test Plan:
1. N=8, K=2 (S=3), out_ready=1; a=8'hFF op=AND, then a=8'hFE op=AND -> c=1 at t+3, c=0 at t+4, out_valid high both cycles.
2. N=8, K=2: a=8'h00 op=NOR; a=8'h10 op=OR; a=8'h07 op=XOR; a=8'h07 op=XNOR -> c = 1, 1, 1, 0 on consecutive cycles, with op_out = 4, 1, 2, 5.
3. N=10, K=4 (S=2, padded group), op=AND, a=10'h3FF -> c=1. op=XOR, a=10'h200 -> c=1. Padding must not corrupt either result.
4. Back-pressure: stream 5 operands, drop out_ready for 4 cycles after the first result -> in_ready falls once S stages are full; no result is lost or duplicated; c stays stable while stalled; order is preserved.
5. op=6 with a=8'hFF -> c=0 and op_err=1, and op_err stays 1. Then assert rst_n=0 mid-stream with 2 operands in flight -> out_valid=0 and op_err=0 immediately; no stale output after release.
6. Random regression vs golden model over N ∈ {2, 7, 8, 33, 64}, K ∈ {2, 3, 4}, random ops and random in_valid/out_ready -> zero mismatches, 1-per-cycle throughput when unstalled.

Source files
------------

// File: rtl/pipelined_unary_reducer_pkg.sv
// Shared types and elaboration helpers for the pipelined unary reducer.
package unary_pkg;

   typedef enum logic [2:0] {
      UOP_AND  = 3'd0,
      UOP_OR   = 3'd1,
      UOP_XOR  = 3'd2,
      UOP_NAND = 3'd3,
      UOP_NOR  = 3'd4,
      UOP_XNOR = 3'd5
   } unary_op_e;

   localparam int MIN_N = 2;
   localparam int MAX_N = 1024;
   localparam int MIN_K = 2;
   localparam int MAX_K = 8;

   // Value that leaves the base operator unchanged when padding a short group.
   function automatic logic identity(input unary_op_e op);
      return (op == UOP_AND) || (op == UOP_NAND);
   endfunction

   // Non-inverted operator the tree actually evaluates.
   function automatic unary_op_e base_op(input unary_op_e op);
      case (op)
         UOP_AND, UOP_NAND: return UOP_AND;
         UOP_XOR, UOP_XNOR: return UOP_XOR;
         default:           return UOP_OR;
      endcase
   endfunction

   function automatic logic is_inverted(input unary_op_e op);
      return (op == UOP_NAND) || (op == UOP_NOR) || (op == UOP_XNOR);
   endfunction

   function automatic logic is_reserved(input logic [2:0] op);
      return op > 3'd5;
   endfunction

   // Number of radix-k levels needed to fold n bits down to one (at least one).
   function automatic int clog_k(input int n, input int k);
      int s;
      int p;
      s = 0;
      p = 1;
      for (int i = 0; i < 32; i++) begin
         if (p < n) begin
            p = p * k;
            s = s + 1;
         end
      end
      return (s < 1) ? 1 : s;
   endfunction

   // Width of the partial-result vector after s levels of folding.
   function automatic int stage_w(input int n, input int k, input int s);
      int w;
      w = n;
      for (int i = 0; i < s; i++) begin
         w = (w + k - 1) / k;
      end
      return w;
   endfunction

endpackage

// File: rtl/pipelined_unary_reducer_if.sv
// Operand/result bus of the pipelined unary reducer.
// Handshake: a beat moves on a rising clk edge when valid && ready are both
// high; the sender holds payload stable while valid && !ready; ready never
// depends combinationally on the valid of the same channel.
interface pipelined_unary_reducer_if #(
   parameter int N = 8
);
   logic [N-1:0] a;
   logic [2:0]   op;
   logic         in_valid;
   logic         in_ready;
   logic         c;
   logic [2:0]   op_out;
   logic         out_valid;
   logic         out_ready;
   logic         op_err;

   modport master (
      output a, op, in_valid, out_ready,
      input  in_ready, c, op_out, out_valid, op_err
   );

   modport slave (
      input  a, op, in_valid, out_ready,
      output in_ready, c, op_out, out_valid, op_err
   );
endinterface

// File: rtl/pipelined_unary_reducer_stage.sv
// One registered level of the reduction tree: folds groups of K bits with the
// base operator, then holds the partial vector, op and valid until the next
// level can take them. The last level also applies inversion / reserved clamp.
module unary_reduce_stage
   import unary_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int K     = 4,
   parameter int LAST  = 0,
   localparam int OUT_W = (IN_W + K - 1) / K
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_bits,
   input  logic [2:0]       in_op,
   input  logic             in_valid,
   input  logic             nxt_ready,
   output logic [OUT_W-1:0] out_bits,
   output logic [2:0]       out_op,
   output logic             out_valid,
   output logic             ready
);

   localparam int PAD_W = OUT_W * K;

   unary_op_e        op_e;
   unary_op_e        bop;
   logic [PAD_W-1:0] pad;
   logic [OUT_W-1:0] red;
   logic [OUT_W-1:0] bits_d, bits_q;
   logic [2:0]       op_d, op_q;
   logic             v_d, v_q;

   assign op_e  = unary_op_e'(in_op);
   assign bop   = base_op(op_e);
   // An empty stage always accepts, so bubbles collapse under a stall.
   assign ready = nxt_ready || !v_q;

   // Fill the operand out to whole groups with the operator's identity value.
   always_comb begin
      pad = {PAD_W{identity(op_e)}};
      pad[IN_W-1:0] = in_bits;
   end

   for (genvar j = 0; j < OUT_W; j++) begin : g_grp
      assign red[j] = (bop == UOP_AND) ? (&pad[j*K +: K]) :
                      (bop == UOP_XOR) ? (^pad[j*K +: K]) :
                                         (|pad[j*K +: K]);
   end

   // Next register contents; only the final level inverts or clamps.
   always_comb begin
      v_d    = in_valid;
      op_d   = in_op;
      bits_d = red;
      if (LAST != 0) begin
         if (is_reserved(in_op)) bits_d = '0;
         else                    bits_d = red ^ {OUT_W{is_inverted(op_e)}};
      end
   end

   // Level registers advance whenever this level can hand off or is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= 1'b0;
         op_q   <= 3'd0;
         bits_q <= '0;
      end else if (ready) begin
         v_q    <= v_d;
         op_q   <= op_d;
         bits_q <= bits_d;
      end
   end

   assign out_bits  = bits_q;
   assign out_op    = op_q;
   assign out_valid = v_q;

endmodule

// File: rtl/pipelined_unary_reducer.sv
// Pipelined N-bit unary reduction (AND/OR/XOR and inverted forms) built from
// S = ceil(log_K(N)) registered radix-K levels with valid/ready flow control.
module pipelined_unary_reducer
   import unary_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   pipelined_unary_reducer_if.slave    bus
);

   localparam int S = clog_k(N, K);

   if (N < MIN_N || N > MAX_N) begin : g_bad_n
      $error("pipelined_unary_reducer: N out of range");
   end
   if (K < MIN_K || K > MAX_K) begin : g_bad_k
      $error("pipelined_unary_reducer: K out of range");
   end

   // Index 0 is the input port; index s is level s. r_s[S+1] is downstream.
   logic [2:0] op_s [0:S];
   logic       v_s  [0:S];
   logic       r_s  [1:S+1];
   logic       c_fin;
   logic       op_err_d, op_err_q;

   assign op_s[0]  = bus.op;
   assign v_s[0]   = bus.in_valid;
   assign r_s[S+1] = bus.out_ready;

   for (genvar s = 1; s <= S; s++) begin : g_stg
      localparam int IW = stage_w(N, K, s - 1);
      localparam int OW = stage_w(N, K, s);

      logic [IW-1:0] in_bits;
      logic [OW-1:0] bits;

      if (s == 1) begin : g_src_in
         assign in_bits = bus.a;
      end else begin : g_src_stg
         assign in_bits = g_stg[s-1].bits;
      end

      unary_reduce_stage #(
         .IN_W (IW),
         .K    (K),
         .LAST ((s == S) ? 1 : 0)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_bits   (in_bits),
         .in_op     (op_s[s-1]),
         .in_valid  (v_s[s-1]),
         .nxt_ready (r_s[s+1]),
         .out_bits  (bits),
         .out_op    (op_s[s]),
         .out_valid (v_s[s]),
         .ready     (r_s[s])
      );

      if (s == S) begin : g_last
         assign c_fin = bits[0];
      end
   end

   // Sticky error: latches once a reserved op is actually accepted.
   always_comb begin
      op_err_d = op_err_q | (bus.in_valid && r_s[1] && is_reserved(bus.op));
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) op_err_q <= 1'b0;
      else        op_err_q <= op_err_d;
   end

   assign bus.in_ready  = r_s[1];
   assign bus.c         = c_fin;
   assign bus.op_out    = op_s[S];
   assign bus.out_valid = v_s[S];
   assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_pipelined_unary_reducer.sv
module tb_pipelined_unary_reducer;

  localparam int NCFG = 7;
  localparam int CFG_N [NCFG] = '{8, 10, 2, 7, 8, 33, 64};
  localparam int CFG_K [NCFG] = '{2, 4, 2, 3, 4, 4, 3};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic rnd_en;
  logic drain_chk;

  // directed drive for configs 0 (N=8,K=2) and 1 (N=10,K=4)
  logic [63:0] dir_a  [2];
  logic [2:0]  dir_op [2];
  logic [1:0]  dir_iv;
  logic [1:0]  dir_or;

  // observation mirrors of every DUT
  logic [NCFG-1:0] obs_c, obs_ov, obs_err, obs_ir;
  logic [2:0]      obs_op  [NCFG];
  int              n_out_m [NCFG];

  logic [7:0] bp_a [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
  logic [7:0] t2_a [4] = '{8'h00, 8'h10, 8'h07, 8'h07};
  logic [2:0] t2_op[4] = '{3'd4, 3'd1, 3'd2, 3'd5};
  logic       t2_c [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic ref_c(input logic [63:0] a, input int n, input logic [2:0] op);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(a[i]);
    case (op)
      3'd0: return ones == n;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return ones != n;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUTs, drivers, scoreboards ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NN = CFG_N[g];
    localparam int KK = CFG_K[g];

    pipelined_unary_reducer_if #(.N(NN)) bus ();

    pipelined_unary_reducer #(.N(NN), .K(KK)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    if (g < 2) begin : g_dir
      assign bus.a         = dir_a[g][NN-1:0];
      assign bus.op        = dir_op[g];
      assign bus.in_valid  = dir_iv[g];
      assign bus.out_ready = dir_or[g];
    end else begin : g_rnd
      logic [NN-1:0] r_a;
      logic [2:0]    r_op;
      logic          r_iv, r_or;
      logic [63:0]   rv;
      int            cnt;
      assign bus.a         = r_a;
      assign bus.op        = r_op;
      assign bus.in_valid  = r_iv;
      assign bus.out_ready = r_or;
      initial begin
        r_a = '0; r_op = 3'd0; r_iv = 1'b0; r_or = 1'b1; cnt = 0;
        forever begin
          @(posedge clk); #1;
          if (rnd_en) begin
            cnt++;
            rv   = {$urandom, $urandom};
            r_a  = rv[NN-1:0];
            r_op = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            if (((cnt / 200) % 3) == 2) begin
              r_iv = 1'b1;
              r_or = 1'b1;
            end else begin
              r_iv = ($urandom_range(0, 3) != 0);
              r_or = ($urandom_range(0, 3) != 0);
            end
          end else begin
            r_iv = 1'b0;
            r_or = 1'b1;
          end
        end
      end
    end

    assign obs_c[g]   = bus.c;
    assign obs_ov[g]  = bus.out_valid;
    assign obs_err[g] = bus.op_err;
    assign obs_ir[g]  = bus.in_ready;
    assign obs_op[g]  = bus.op_out;

    logic [3:0] exp_q[$];
    logic [3:0] e;
    logic       stall_p, c_p, err_exp, drained;
    logic [2:0] op_p;
    int         n_out;
    assign n_out_m[g] = n_out;

    initial begin
      stall_p = 1'b0; c_p = 1'b0; op_p = 3'd0; err_exp = 1'b0; drained = 1'b0; n_out = 0;
    end

    // scoreboard: outputs vs queued model results, stall stability, sticky error
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        stall_p = 1'b0;
        err_exp = 1'b0;
      end else begin
        chk($sformatf("cfg%0d_op_err", g), bus.op_err, err_exp);
        if (bus.out_ready) chk($sformatf("cfg%0d_in_ready_unstalled", g), bus.in_ready, 1);
        if (stall_p) begin
          chk($sformatf("cfg%0d_stall_valid", g), bus.out_valid, 1);
          chk($sformatf("cfg%0d_stall_c", g), bus.c, c_p);
          chk($sformatf("cfg%0d_stall_op", g), bus.op_out, op_p);
        end
        if (bus.out_valid && bus.out_ready) begin
          chk($sformatf("cfg%0d_out_expected", g), exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("cfg%0d_c", g), bus.c, e[3]);
            chk($sformatf("cfg%0d_op_out", g), bus.op_out, e[2:0]);
            n_out++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back({ref_c(64'(bus.a), NN, bus.op), bus.op});
          if (bus.op > 3'd5) err_exp = 1'b1;
        end
        stall_p = bus.out_valid && !bus.out_ready;
        c_p     = bus.c;
        op_p    = bus.op_out;
        if (drain_chk && !drained) begin
          chk($sformatf("cfg%0d_queue_empty", g), exp_q.size(), 0);
          drained = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic [63:0] a, input logic [2:0] op, input logic iv);
    dir_a[u]  = a;
    dir_op[u] = op;
    dir_iv[u] = iv;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int sent;
    int base;
    total = 0; bad = 0;
    rnd_en = 1'b0; drain_chk = 1'b0;
    dir_a[0] = '0; dir_a[1] = '0; dir_op[0] = 3'd0; dir_op[1] = 3'd0;
    dir_iv = 2'b00; dir_or = 2'b11;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", obs_ov[0], 0);
    chk("rst_c", obs_c[0], 0);
    chk("rst_op_out", obs_op[0], 0);
    chk("rst_op_err", obs_err[0], 0);
    chk("rst_in_ready", obs_ir[0], 1);
    chk("rst_out_valid_n10", obs_ov[1], 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // 1: AND of FF then FE, latency 3
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        chk("t1_valid0", obs_ov[0], 1); chk("t1_c0", obs_c[0], 1); chk("t1_op0", obs_op[0], 0);
      end
      if (i == 4) begin
        chk("t1_valid1", obs_ov[0], 1); chk("t1_c1", obs_c[0], 0);
      end
      if (i == 5) chk("t1_idle", obs_ov[0], 0);
      if (i == 0)      drive(0, 64'hFF, 3'd0, 1'b1);
      else if (i == 1) drive(0, 64'hFE, 3'd0, 1'b1);
      else             drive(0, 64'h0, 3'd0, 1'b0);
      tick;
    end

    // 2: back-to-back NOR, OR, XOR, XNOR
    for (int i = 0; i < 8; i++) begin
      if (i >= 3 && i <= 6) begin
        chk($sformatf("t2_valid%0d", i - 3), obs_ov[0], 1);
        chk($sformatf("t2_c%0d", i - 3), obs_c[0], t2_c[i-3]);
        chk($sformatf("t2_op%0d", i - 3), obs_op[0], t2_op[i-3]);
      end
      if (i == 7) chk("t2_idle", obs_ov[0], 0);
      if (i < 4) drive(0, 64'(t2_a[i]), t2_op[i], 1'b1);
      else       drive(0, 64'h0, 3'd0, 1'b0);
      tick;
    end

    // 3: N=10 K=4 padded group
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin chk("t3_and_valid", obs_ov[1], 1); chk("t3_and_c", obs_c[1], 1); end
      if (i == 3) begin chk("t3_xor_valid", obs_ov[1], 1); chk("t3_xor_c", obs_c[1], 1); end
      if (i == 0)      drive(1, 64'h3FF, 3'd0, 1'b1);
      else if (i == 1) drive(1, 64'h200, 3'd2, 1'b1);
      else             drive(1, 64'h0, 3'd0, 1'b0);
      tick;
    end

    // 4: back-pressure, out_ready low for cycles 4..7
    sent = 0;
    base = n_out_m[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      dir_or[0] = !(cyc >= 4 && cyc <= 7);
      if (sent < 5) drive(0, 64'(bp_a[sent]), 3'd2, 1'b1);
      else          drive(0, 64'h0, 3'd0, 1'b0);
      #1;
      if (cyc == 4) chk("t4_in_ready_low", obs_ir[0], 0);
      if (cyc == 5) chk("t4_stall_valid", obs_ov[0], 1);
      if (cyc == 8) chk("t4_in_ready_back", obs_ir[0], 1);
      if (sent < 5 && obs_ir[0]) sent++;
      tick;
    end
    dir_or[0] = 1'b1;
    chk("t4_all_sent", sent, 5);
    chk("t4_out_count", n_out_m[0] - base, 5);

    // 5: reserved op, then reset with operands in flight
    drive(0, 64'hFF, 3'd6, 1'b1);
    tick;
    chk("t5_err_set", obs_err[0], 1);
    drive(0, 64'hFF, 3'd0, 1'b1);
    tick;
    drive(0, 64'hFF, 3'd0, 1'b1);
    tick;
    chk("t5_rsv_valid", obs_ov[0], 1);
    chk("t5_rsv_c", obs_c[0], 0);
    chk("t5_rsv_op", obs_op[0], 6);
    chk("t5_err_sticky", obs_err[0], 1);
    drive(0, 64'h0, 3'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", obs_ov[0], 0);
    chk("t5_rst_err", obs_err[0], 0);
    chk("t5_rst_c", obs_c[0], 0);
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_no_stale%0d", i), obs_ov[0], 0);
      tick;
    end

    // 6: random regression on all configs
    rnd_en = 1'b1;
    repeat (3000) tick;
    rnd_en = 1'b0;
    repeat (30) tick;
    drain_chk = 1'b1;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
